// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with sub-word read-modify-write
module load_store_unit #(
  parameter int MEM_WORDS  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_store_data,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_load_data,
  output logic                  resp_fault,
  output logic                  stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  state_t                  state, state_next;
  logic                    r_write;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_store_data;
  logic                    r_fault;
  logic [31:0]             r_merged;
  logic [31:0]             r_load_data;

  logic                    req_fault;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             lane_load;
  logic [31:0]             lane_merge;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  // Classify an incoming request: illegal size, misalignment or word index past the memory.
  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      SZ_HALF: req_fault = req_address[0];
      SZ_WORD: req_fault = |req_address[1:0];
      SZ_BYTE: req_fault = 1'b0;
      default: req_fault = 1'b1;
    endcase
    if (req_address[ADDR_WIDTH-1:2] >= WORD_LIMIT) req_fault = 1'b1;
  end

  // Little-endian lane extraction and extension of the word read back from memory.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    byte_sel = mem_read_data[7:0];
      2'd1:    byte_sel = mem_read_data[15:8];
      2'd2:    byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_size)
      SZ_BYTE: lane_load = {{24{~r_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: lane_load = {{16{~r_unsigned & half_sel[15]}}, half_sel};
      default: lane_load = mem_read_data;
    endcase
  end

  // Merge the store lane into the current memory word for sub-word stores.
  always_comb begin
    lane_merge = mem_read_data;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0:    lane_merge[7:0]   = r_store_data[7:0];
        2'd1:    lane_merge[15:8]  = r_store_data[7:0];
        2'd2:    lane_merge[23:16] = r_store_data[7:0];
        default: lane_merge[31:24] = r_store_data[7:0];
      endcase
    end else if (r_addr[1]) begin
      lane_merge[31:16] = r_store_data[15:0];
    end else begin
      lane_merge[15:0] = r_store_data[15:0];
    end
  end

  // State register; reset drops straight to IDLE so an in-flight write strobe dies immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory/handshake outputs.
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_fault ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_address = word_addr;
        if (r_write && r_size == SZ_WORD) begin
          mem_write      = 1'b1;
          mem_write_data = r_store_data;
          state_next     = RESP;
        end else if (r_write) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
        end
      end
      WRITE: begin
        mem_address    = word_addr;
        mem_write      = 1'b1;
        mem_write_data = r_merged;
        state_next     = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Request capture on accept, then load result or merged word captured during ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_fault      <= 1'b0;
      r_merged     <= '0;
      r_load_data  <= '0;
    end else if (state == IDLE && req_valid) begin
      r_write      <= req_write;
      r_size       <= req_size;
      r_unsigned   <= req_unsigned;
      r_addr       <= req_address;
      r_store_data <= req_store_data;
      r_fault      <= req_fault;
      r_load_data  <= '0;
    end else if (state == ACCESS) begin
      if (r_write) r_merged    <= lane_merge;
      else         r_load_data <= lane_load;
    end
  end

  assign resp_fault     = resp_valid & r_fault;
  assign resp_load_data = resp_valid ? r_load_data : '0;
  assign stall          = ~req_ready;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access controller between the EX/MEM pipeline register and the word-addressed data memory.
- Accepts one load or store request at a time and handles byte, halfword and word sizes.
- Performs read-modify-write for sub-word stores, because the memory only writes full words.
- Sign- or zero-extends loads, flags misaligned and out-of-range accesses, and drives a stall to the pipeline while busy.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  request present from EX/MEM
- req_ready  out  1  unit idle and able to accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_address  in  ADDR_WIDTH  byte address
- req_store_data  in  32  store data, right-justified
- mem_write  out  1  write strobe to data memory
- mem_address  out  ADDR_WIDTH  word-aligned address to data memory (bits [1:0] = 00)
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from data memory
- resp_valid  out  1  one-cycle pulse: access complete
- resp_load_data  out  32  extended load result, valid with resp_valid
- resp_fault  out  1  misaligned/illegal/out-of-range, valid with resp_valid
- stall  out  1  equals ~req_ready

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. req_ready=1, mem_write=0, resp_valid=0, resp_fault=0, resp_load_data=0, internal request registers=0. Must take effect immediately, including mid-RMW; no write may be issued after reset asserts.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch write, size, unsigned, address and store data.
  - Go to RESP with fault set if any of these hold: size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr[ADDR_WIDTH-1:2] >= MEM_WORDS. No memory access is made for a faulted request.
  - Otherwise go to ACCESS.
- ACCESS (request accepted at edge N, so this is cycle N+1):
  - mem_address = {latched addr[ADDR_WIDTH-1:2], 2'b00}.
  - Load: select the lane from mem_read_data and extend it, then register into resp_load_data. Lanes are little-endian: byte k = bits[8k+7:8k] where k=addr[1:0]; half h = bits[16h+15:16h] where h=addr[1]. Next state RESP.
  - Word store: mem_write=1 and mem_write_data=store data in this cycle. Next state RESP.
  - Sub-word store: register merged word = mem_read_data with the selected lane replaced by store data [7:0] or [15:0]. mem_write=0. Next state WRITE.
- WRITE: mem_write=1, mem_write_data=merged register, same mem_address. Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_fault as latched.
  - For stores and faults, resp_load_data=0.
  - Next state IDLE; req_ready=1 from the following cycle. No back-pressure on the response.
- mem_write is asserted only in ACCESS (word store) or WRITE, and for exactly one cycle per store.
- mem_address and mem_write_data outputs are 0 in IDLE and RESP.
- Latency from accept edge to resp_valid:
  - load / word store: resp_valid in cycle N+2
  - sub-word store: cycle N+3
  - fault: cycle N+1
- req_valid in a non-IDLE state is ignored; the requester holds it until it sees req_ready.
- Back-to-back requests: the next accept is at the edge leaving RESP+1, i.e. at most one request in flight.

Test Plan:
- Memory preloaded word i = i. Load word at 0x14, unsigned=0 -> resp_valid at N+2, resp_load_data=0x00000005, fault=0, mem_write never high.
- Store byte 0xAB at 0x09 -> mem_write high for one cycle in cycle N+2 with mem_address=0x08 and mem_write_data=0x0000AB02; resp_valid at N+3; subsequent word load at 0x08 returns 0x0000AB02.
- After the previous store: load byte signed at 0x09 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB; load half signed at 0x08 -> 0xFFFFAB02.
- Half load at 0x03, word store at 0x06, and word load at 0x100 (index 64) -> each gives resp_valid at N+1 with fault=1 and no mem_write pulse.
- Store half 0x1234 at 0x12 -> written word 0x12340004; stall=1 for cycles N+1..N+3, 0 otherwise.
- Assert reset during the WRITE-bound RMW (after ACCESS) -> mem_write stays 0; outputs return to reset values asynchronously; memory word is unchanged; a fresh request after release completes normally.
